regfile_read_arbiter: RTL and testbench

Sequencer and round-robin arbiter that shares the register file's single 16:1 one-hot read multiplexer between up to eight requesters. It accepts register-read requests, drives the multiplexer's one-hot select, and waits a fixed number of settle cycles for the gate-level mux to resolve. It then captures the 8-bit result and returns it to the winning requester with a one-cycle acknowledge. It sits between the CPU's read clients (operand fetch, debug port, DMA) and the register-file read datapath.

---
 rtl/regfile_read_arbiter_if.sv | 34 +++
 rtl/regfile_read_arbiter.sv | 152 +++++++++++++++
 tb/tb_regfile_read_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_read_arbiter_if.sv
// Bundle between the read clients, the register-file read mux and the
// arbiter. The master side is the environment (requesters plus the mux
// datapath); the slave side is the arbiter itself.
interface regfile_read_arbiter_if #(
   parameter int unsigned N_REQ = 4
);
   logic [N_REQ-1:0] req;
   logic [3:0]       addr [N_REQ-1:0];
   logic [N_REQ-1:0] ack;
   logic [7:0]       rdata;
   logic             busy;
   logic [15:0]      sel;
   logic [7:0]       res;

   modport master (
      output req,
      output addr,
      output res,
      input  ack,
      input  rdata,
      input  busy,
      input  sel
   );

   modport slave (
      input  req,
      input  addr,
      input  res,
      output ack,
      output rdata,
      output busy,
      output sel
   );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin sequencer sharing the register file's single 16:1 one-hot read
// mux between up to eight requesters. It holds the select for a fixed number
// of settle cycles, captures the mux output and returns it with a one-cycle
// acknowledge to the winner.
module regfile_read_arbiter #(
   parameter int unsigned N_REQ         = 4,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input logic                   clk,
   input logic                   rst_n,
   regfile_read_arbiter_if.slave bus
);

   localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StSettle, StDone} state_e;

   state_e           r_state;
   state_e           w_state_nxt;
   logic [PtrW-1:0]  r_ptr;
   logic [PtrW-1:0]  r_gnt;
   logic [CntW-1:0]  r_cnt;
   logic [15:0]      r_sel;
   logic [7:0]       r_rdata;

   logic [N_REQ-1:0] w_gnt_oh;
   logic [N_REQ-1:0] w_req_masked;
   logic [PtrW-1:0]  w_win;
   logic             w_found;
   logic             w_grant;
   logic [15:0]      w_sel_dec;
   int unsigned      w_cand;

   // One-hot of the current winner, used both for DONE masking and for ack.
   always_comb begin
      w_gnt_oh        = '0;
      w_gnt_oh[r_gnt] = 1'b1;
   end

   // The winner's req may still be high in its DONE cycle; hide it there.
   always_comb begin
      w_req_masked = bus.req;
      if (r_state == StDone) begin
         w_req_masked = bus.req & ~w_gnt_oh;
      end
   end

   // Round-robin search from r_ptr upward, wrapping inside 0..N_REQ-1.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         w_cand = 32'(r_ptr) + i;
         if (w_cand >= N_REQ) begin
            w_cand = w_cand - N_REQ;
         end
         if (!w_found && w_req_masked[PtrW'(w_cand)]) begin
            w_found = 1'b1;
            w_win   = PtrW'(w_cand);
         end
      end
   end

   // Arbitration only happens from IDLE or DONE; SETTLE is never interrupted.
   always_comb begin
      w_grant = w_found && ((r_state == StIdle) || (r_state == StDone));
   end

   // One-hot decode of the winning requester's address.
   always_comb begin
      w_sel_dec                 = '0;
      w_sel_dec[bus.addr[w_win]] = 1'b1;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_grant) begin
               w_state_nxt = StSettle;
            end
         end
         StSettle: begin
            if (r_cnt == '0) begin
               w_state_nxt = StDone;
            end
         end
         StDone: begin
            w_state_nxt = w_grant ? StSettle : StIdle;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // Datapath: latch winner and select on grant, count settle, capture result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_cnt   <= '0;
         r_sel   <= '0;
         r_rdata <= '0;
      end else if (w_grant) begin
         r_gnt <= w_win;
         r_sel <= w_sel_dec;
         r_cnt <= CntLoad;
         if (32'(w_win) == N_REQ - 1) begin
            r_ptr <= '0;
         end else begin
            r_ptr <= w_win + 1'b1;
         end
      end else if (r_state == StSettle) begin
         if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end else begin
            r_rdata <= bus.res;
            r_sel   <= '0;
         end
      end
   end

   // Outputs: registered select and data, ack decoded from the DONE state.
   always_comb begin
      bus.sel   = r_sel;
      bus.rdata = r_rdata;
      bus.busy  = (r_state != StIdle);
      bus.ack   = '0;
      if (r_state == StDone) begin
         bus.ack = w_gnt_oh;
      end
   end

   // The mux select and the acknowledge must never be multi-hot.
   a_sel_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_sel));
   a_ack_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.ack));

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed and randomized bench for regfile_read_arbiter: one instance with a
// single settle cycle backed by a register-file model, one with three settle
// cycles whose mux output is driven by hand.
module tb_regfile_read_arbiter;

   localparam int unsigned N     = 4;
   localparam int          Bound = 2 * N + 2;

   typedef struct packed {
      logic [N-1:0] ack;
      logic [7:0]   data;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   regfile_read_arbiter_if #(.N_REQ(N)) bus1 ();
   regfile_read_arbiter_if #(.N_REQ(N)) bus3 ();

   regfile_read_arbiter #(.N_REQ(N), .SETTLE_CYCLES(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   regfile_read_arbiter #(.N_REQ(N), .SETTLE_CYCLES(3)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3)
   );

   logic [7:0] regs [16];

   // Register-file read mux model for the single-settle instance.
   always_comb begin
      bus1.res = 8'h00;
      for (int i = 0; i < 16; i++) begin
         if (bus1.sel[i]) bus1.res = regs[i];
      end
   end

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q [$];

   logic [7:0] rq [N][$];
   int         wt [N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Waits for an ack on dut1; every non-ack cycle must be a held select.
   task automatic wait_ack(input string tag, input int budget, output int cyc);
      exp_t e;
      cyc = 0;
      while (cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (bus1.ack != '0) break;
         chk({tag, "_sel_held"}, 32'($onehot(bus1.sel)), 1);
      end
      chk({tag, "_ack_seen"}, 32'(bus1.ack != '0), 1);
      if (bus1.ack != '0) begin
         if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_ack"}, 32'(bus1.ack), 0);
         end else begin
            e = exp_q.pop_front();
            chk({tag, "_ack"}, 32'(bus1.ack), 32'(e.ack));
            chk({tag, "_rdata"}, 32'(bus1.rdata), 32'(e.data));
         end
      end
   endtask

   task automatic chk_idle1(input string tag);
      chk({tag, "_sel"}, 32'(bus1.sel), 0);
      chk({tag, "_ack"}, 32'(bus1.ack), 0);
      chk({tag, "_busy"}, 32'(bus1.busy), 0);
   endtask

   initial begin
      int   cyc;
      logic stim_on;
      logic [3:0] a;

      for (int i = 0; i < 16; i++) regs[i] = 8'h30 + 8'(i);
      for (int i = 0; i < 4; i++) regs[i] = 8'h10 + 8'(i);
      regs[5] = 8'hA5;
      bus1.req = '0;
      bus3.req = '0;
      bus3.res = 8'h00;
      for (int i = 0; i < N; i++) begin
         bus1.addr[i] = 4'd0;
         bus3.addr[i] = 4'd0;
      end

      // Reset state
      repeat (2) @(negedge clk);
      chk_idle1("rst");
      chk("rst_rdata", 32'(bus1.rdata), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle1("post_rst");

      // Single read: req2 -> reg5
      bus1.addr[2] = 4'd5;
      bus1.req     = 4'b0100;
      exp_q.push_back('{ack: 4'b0100, data: 8'hA5});
      @(negedge clk);
      chk("single_sel", 32'(bus1.sel), 32'h0020);
      chk("single_busy", 32'(bus1.busy), 1);
      chk("single_noack", 32'(bus1.ack), 0);
      wait_ack("single", 4, cyc);
      chk("single_lat", 32'(cyc), 1);
      bus1.req = '0;
      @(negedge clk);
      chk_idle1("single_end");

      // Wrap: ptr=3 now, so req3 beats req0
      bus1.addr[0] = 4'd1;
      bus1.addr[3] = 4'd2;
      bus1.req     = 4'b1001;
      exp_q.push_back('{ack: 4'b1000, data: regs[2]});
      exp_q.push_back('{ack: 4'b0001, data: regs[1]});
      wait_ack("wrap_a", 6, cyc);
      chk("wrap_a_lat", 32'(cyc), 2);
      bus1.req[3] = 1'b0;
      wait_ack("wrap_b", 6, cyc);
      chk("wrap_b_lat", 32'(cyc), 2);
      bus1.req = '0;
      @(negedge clk);
      chk_idle1("wrap_end");

      // Reset mid-SETTLE: ptr=1, so req2 is in flight when reset hits
      bus1.addr[0] = 4'd8;
      bus1.addr[2] = 4'd9;
      bus1.req     = 4'b0101;
      @(negedge clk);
      chk("midrst_sel_before", 32'(bus1.sel), 32'h0200);
      #2 rst_n = 1'b0;
      #1;
      chk_idle1("midrst");
      chk("midrst_rdata", 32'(bus1.rdata), 0);
      repeat (2) begin
         @(negedge clk);
         chk("midrst_hold_ack", 32'(bus1.ack), 0);
      end
      rst_n = 1'b1;
      exp_q.push_back('{ack: 4'b0001, data: regs[8]});
      exp_q.push_back('{ack: 4'b0100, data: regs[9]});
      wait_ack("midrst_a", 6, cyc);
      chk("midrst_a_lat", 32'(cyc), 2);
      bus1.req[0] = 1'b0;
      wait_ack("midrst_b", 6, cyc);
      chk("midrst_b_lat", 32'(cyc), 2);
      bus1.req = '0;
      @(negedge clk);

      // Fairness from a fresh pointer: all four at once
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) begin
         bus1.addr[i] = 4'(i);
         exp_q.push_back('{ack: 4'(1 << i), data: regs[i]});
      end
      bus1.req = 4'b1111;
      for (int i = 0; i < N; i++) begin
         wait_ack("fair", 6, cyc);
         chk("fair_lat", 32'(cyc), 2);
         bus1.req[i] = 1'b0;
      end
      @(negedge clk);
      chk_idle1("fair_end");

      // Settle=3: res changes late, only the final value may be captured
      bus3.addr[0] = 4'd4;
      bus3.res     = 8'h11;
      bus3.req     = 4'b0001;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk("settle_sel", 32'(bus3.sel), 32'h0010);
         chk("settle_noack", 32'(bus3.ack), 0);
         if (c == 3) bus3.res = 8'h5C;
      end
      @(negedge clk);
      chk("settle_ack", 32'(bus3.ack), 1);
      chk("settle_rdata", 32'(bus3.rdata), 32'h5C);
      chk("settle_sel_clr", 32'(bus3.sel), 0);
      bus3.req = '0;
      @(negedge clk);
      chk("settle_busy_end", 32'(bus3.busy), 0);

      // Randomized traffic
      for (int i = 0; i < 16; i++) regs[i] = 8'($urandom);
      for (int i = 0; i < N; i++) wt[i] = 0;
      for (int c = 0; c < 10200; c++) begin
         stim_on = (c < 10000);
         if (!stim_on && bus1.req == '0) break;
         @(negedge clk);
         chk("rnd_sel_onehot0", 32'($onehot0(bus1.sel)), 1);
         chk("rnd_ack_onehot0", 32'($onehot0(bus1.ack)), 1);
         for (int i = 0; i < N; i++) begin
            if (bus1.req[i]) wt[i]++;
            if (bus1.ack[i]) begin
               if (rq[i].size() == 0) begin
                  chk("rnd_unexpected_ack", 32'(bus1.ack), 0);
               end else begin
                  chk("rnd_rdata", 32'(bus1.rdata), 32'(rq[i].pop_front()));
                  chk("rnd_wait", 32'(wt[i] <= Bound), 1);
               end
               bus1.req[i] = 1'b0;
               if (stim_on && $urandom_range(1, 0) == 1) begin
                  a = 4'($urandom);
                  bus1.addr[i] = a;
                  bus1.req[i]  = 1'b1;
                  rq[i].push_back(regs[a]);
                  wt[i] = 0;
               end
            end else if (!bus1.req[i] && stim_on && $urandom_range(2, 0) == 0) begin
               a = 4'($urandom);
               bus1.addr[i] = a;
               bus1.req[i]  = 1'b1;
               rq[i].push_back(regs[a]);
               wt[i] = 0;
            end else if (!bus1.req[i] && $urandom_range(1, 0) == 1) begin
               bus1.addr[i] = 4'($urandom);
            end
         end
      end
      chk("rnd_drained", 32'(bus1.req), 0);
      for (int i = 0; i < N; i++) chk("rnd_queue_empty", 32'(rq[i].size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
